// File: rtl/config_bank_pkg.sv
// Shared types and default geometry for the configuration-bank writer family.
package config_bank_pkg;

  // Writer sequencing states.
  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    WRITE,
    DONE
  } state_t;

  // Default bank geometry, reused by bank wrappers and benches.
  localparam int DEF_BL_WIDTH     = 8;
  localparam int DEF_WL_NUM       = 16;
  localparam int DEF_CLEAR_CYCLES = 2;

endpackage

// File: rtl/config_bank_writer_if.sv
// Bundle of the serial stream input, latch-side outputs and status flags.
// master = bitstream source / controller, slave = the bank writer.
interface config_bank_writer_if
  import config_bank_pkg::*;
#(
  parameter int BL_WIDTH = DEF_BL_WIDTH,
  parameter int WL_NUM   = DEF_WL_NUM
);
  logic                start;
  logic                din;
  logic                din_valid;
  logic                din_ready;
  logic [BL_WIDTH-1:0] bl;
  logic [WL_NUM-1:0]   wl;
  logic                cfg_reset;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output start, din, din_valid,
    input  din_ready, bl, wl, cfg_reset, busy, done, err
  );

  modport slave (
    input  start, din, din_valid,
    output din_ready, bl, wl, cfg_reset, busy, done, err
  );
endinterface

// File: rtl/config_wl_decoder.sv
// Registered address-to-one-hot word-line decoder. With en low every line
// is driven low on the next edge, so at most one line is ever high.
module config_wl_decoder #(
  parameter int ADDR_W = 4,
  parameter int WL_NUM = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [WL_NUM-1:0] wl
);

  genvar gi;
  generate
    for (gi = 0; gi < WL_NUM; gi++) begin : g_wl
      logic line_reg;

      // One flop per word line; set only when enabled and addressed.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          line_reg <= 1'b0;
        end else begin
          line_reg <= en && (addr == ADDR_W'(gi));
        end
      end

      assign wl[gi] = line_reg;
    end
  endgenerate

endmodule

// File: rtl/config_bank_writer.sv
// Serial-to-frame loader for a bank of configuration latches: optional
// clear pulse, then BL_WIDTH-bit frames written to word lines 0..WL_NUM-1.
module config_bank_writer
  import config_bank_pkg::*;
#(
  parameter int BL_WIDTH     = DEF_BL_WIDTH,
  parameter int WL_NUM       = DEF_WL_NUM,
  parameter int CLEAR_CYCLES = DEF_CLEAR_CYCLES
) (
  input logic                 clk,
  input logic                 reset,
  config_bank_writer_if.slave bus
);

  localparam int ADDR_W = $clog2(WL_NUM);
  localparam int BC_W   = $clog2(BL_WIDTH);
  localparam int CLR_W  = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(WL_NUM - 1);
  localparam logic [BC_W-1:0]   BIT_LAST  = BC_W'(BL_WIDTH - 1);
  localparam logic [CLR_W-1:0]  CLR_LAST  = CLR_W'((CLEAR_CYCLES > 0) ? CLEAR_CYCLES - 1 : 0);
  // A zero-length clear skips straight to shifting.
  localparam state_t LOAD_ENTRY = (CLEAR_CYCLES == 0) ? SHIFT : CLEAR;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [BC_W-1:0]     bit_cnt_reg, bit_cnt_next;
  logic [CLR_W-1:0]    clr_cnt_reg, clr_cnt_next;
  logic [BL_WIDTH-1:0] bl_reg, bl_next;
  logic                err_reg, err_next;
  logic                cfg_reset_reg;
  logic                wl_en;

  // Next-state, counter and shift-register update logic.
  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    bit_cnt_next = bit_cnt_reg;
    clr_cnt_next = clr_cnt_reg;
    bl_next      = bl_reg;
    err_next     = err_reg;
    case (state_reg)
      IDLE, DONE: begin
        // Data offered after the bank is full is an overrun.
        if (state_reg == DONE && bus.din_valid) begin
          err_next = 1'b1;
        end
        if (bus.start) begin
          state_next   = LOAD_ENTRY;
          addr_next    = '0;
          bit_cnt_next = '0;
          clr_cnt_next = '0;
          err_next     = 1'b0;
        end
      end
      CLEAR: begin
        if (clr_cnt_reg == CLR_LAST) begin
          state_next = SHIFT;
        end else begin
          clr_cnt_next = clr_cnt_reg + CLR_W'(1);
        end
      end
      SHIFT: begin
        // din_ready is high throughout SHIFT, so din_valid is the handshake.
        if (bus.din_valid) begin
          bl_next      = {bl_reg[BL_WIDTH-2:0], bus.din};
          bit_cnt_next = bit_cnt_reg + BC_W'(1);
          if (bit_cnt_reg == BIT_LAST) begin
            state_next = WRITE;
          end
        end
      end
      WRITE: begin
        bit_cnt_next = '0;
        if (addr_reg == ADDR_LAST) begin
          state_next = DONE;
        end else begin
          addr_next  = addr_reg + ADDR_W'(1);
          state_next = SHIFT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; outputs that must be registered follow state_next.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      bit_cnt_reg   <= '0;
      clr_cnt_reg   <= '0;
      bl_reg        <= '0;
      err_reg       <= 1'b0;
      cfg_reset_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      bit_cnt_reg   <= bit_cnt_next;
      clr_cnt_reg   <= clr_cnt_next;
      bl_reg        <= bl_next;
      err_reg       <= err_next;
      cfg_reset_reg <= (state_next == CLEAR);
    end
  end

  // The decoder registers its output, so enabling it one cycle early makes
  // the wl pulse coincide exactly with the WRITE state. addr is stable then.
  assign wl_en = (state_next == WRITE);

  config_wl_decoder #(
    .ADDR_W (ADDR_W),
    .WL_NUM (WL_NUM)
  ) u_wl_decoder (
    .clk   (clk),
    .reset (reset),
    .en    (wl_en),
    .addr  (addr_reg),
    .wl    (bus.wl)
  );

  assign bus.bl        = bl_reg;
  assign bus.cfg_reset = cfg_reset_reg;
  assign bus.err       = err_reg;
  assign bus.din_ready = (state_reg == SHIFT);
  assign bus.busy      = (state_reg == CLEAR) || (state_reg == SHIFT) || (state_reg == WRITE);
  assign bus.done      = (state_reg == DONE);

endmodule

// File: tb/tb_config_bank_writer.sv
// Scoreboard bench for config_bank_writer: a 2-cycle-clear instance (a) and a
// zero-clear instance (z), both 8-bit frames by 4 word lines.
module tb_config_bank_writer;
  import config_bank_pkg::*;

  localparam int BL          = DEF_BL_WIDTH;
  localparam int WL          = 4;
  localparam int CLR         = 2;
  localparam int LOAD_BUDGET = 2000;
  localparam int FULL_A      = CLR + WL * (BL + 1);
  localparam int FULL_Z      = WL * (BL + 1);

  typedef struct packed {
    logic [WL-1:0] wl;
    logic [BL-1:0] bl;
  } sb_item_t;

  logic clk = 1'b0;
  logic reset_a;
  logic reset_z;

  int errors = 0;
  int checks = 0;

  sb_item_t      sb_q[$];
  logic [BL-1:0] frame_mem [WL];
  logic [WL-1:0] prev_wl = '0;

  config_bank_writer_if #(.BL_WIDTH(BL), .WL_NUM(WL)) bus_a ();
  config_bank_writer_if #(.BL_WIDTH(BL), .WL_NUM(WL)) bus_z ();

  config_bank_writer #(.BL_WIDTH(BL), .WL_NUM(WL), .CLEAR_CYCLES(CLR)) dut_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (bus_a)
  );

  config_bank_writer #(.BL_WIDTH(BL), .WL_NUM(WL), .CLEAR_CYCLES(0)) dut_z (
    .clk   (clk),
    .reset (reset_z),
    .bus   (bus_z)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor for instance a: every wl pulse pops one expected frame.
  always @(negedge clk) begin
    sb_item_t want;
    if (bus_a.wl !== '0) begin
      $display("write wl=%b bl=%h", bus_a.wl, bus_a.bl);
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got wl=%b bl=%h, required no write", bus_a.wl, bus_a.bl);
      end else begin
        want = sb_q.pop_front();
        if (bus_a.wl !== want.wl || bus_a.bl !== want.bl) begin
          errors++;
          $display("FAIL sb_frame: got wl=%b bl=%h, required wl=%b bl=%h",
                   bus_a.wl, bus_a.bl, want.wl, want.bl);
        end
      end
      checks++;
      if (bus_a.din_ready !== 1'b0) begin
        errors++;
        $display("FAIL ready_in_write: got %b, required 0", bus_a.din_ready);
      end
      checks++;
      if (prev_wl !== '0) begin
        errors++;
        $display("FAIL wl_pulse_width: previous wl=%b, required 0", prev_wl);
      end
    end
    if (bus_a.cfg_reset === 1'b1) begin
      checks++;
      if (bus_a.din_ready !== 1'b0) begin
        errors++;
        $display("FAIL ready_in_clear: got %b, required 0", bus_a.din_ready);
      end
    end
    prev_wl = bus_a.wl;
  end

  task automatic random_frames();
    for (int i = 0; i < WL; i++) frame_mem[i] = BL'($urandom);
  endtask

  task automatic push_frames(input int count);
    sb_item_t it;
    for (int i = 0; i < count; i++) begin
      it.wl    = '0;
      it.wl[i] = 1'b1;
      it.bl    = frame_mem[i];
      sb_q.push_back(it);
    end
  endtask

  // Streams frame_mem MSB-first into instance a. Called at posedge+1.
  task automatic run_load(input int valid_pct, input bit do_start, input int stop_wl,
                          input int restart_at, output int elapsed, output int clr_seen,
                          output bit stopped);
    int   idx = 0;
    int   cyc = 0;
    logic rdy;
    elapsed  = -1;
    clr_seen = 0;
    stopped  = 1'b0;
    bus_a.start = do_start;
    while (cyc < LOAD_BUDGET) begin
      if (idx < WL * BL && int'($urandom_range(99)) < valid_pct) begin
        bus_a.din_valid = 1'b1;
        bus_a.din       = frame_mem[idx / BL][BL - 1 - (idx % BL)];
      end else begin
        bus_a.din_valid = 1'b0;
        bus_a.din       = 1'($urandom_range(1));
      end
      rdy = bus_a.din_ready;
      @(posedge clk); #1;
      cyc++;
      if (bus_a.din_valid && rdy) idx++;
      bus_a.start = (cyc == restart_at);
      if (bus_a.cfg_reset) clr_seen++;
      if (stop_wl >= 0 && bus_a.wl[stop_wl]) begin
        stopped = 1'b1;
        break;
      end
      if (bus_a.done) begin
        elapsed = cyc - 1;
        break;
      end
    end
    bus_a.din_valid = 1'b0;
    bus_a.start     = 1'b0;
  endtask

  task automatic test_reset();
    bus_a.start = 1'b0; bus_a.din = 1'b0; bus_a.din_valid = 1'b0;
    bus_z.start = 1'b0; bus_z.din = 1'b0; bus_z.din_valid = 1'b0;
    reset_a = 1'b0;
    reset_z = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus_a.bl, bus_a.wl, bus_a.cfg_reset, bus_a.din_ready, bus_a.busy, bus_a.done, bus_a.err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got bl=%h wl=%b cfg=%b rdy=%b busy=%b done=%b err=%b, required all 0",
               bus_a.bl, bus_a.wl, bus_a.cfg_reset, bus_a.din_ready, bus_a.busy, bus_a.done, bus_a.err);
    end
    reset_a = 1'b1;
    reset_z = 1'b1;
    for (int c = 0; c < 20; c++) begin
      bus_a.din_valid = 1'($urandom_range(1));
      bus_a.din       = 1'($urandom_range(1));
      @(posedge clk); #1;
      checks++;
      if ({bus_a.bl, bus_a.wl, bus_a.cfg_reset, bus_a.din_ready, bus_a.busy, bus_a.done, bus_a.err,
           bus_z.bl, bus_z.wl, bus_z.cfg_reset, bus_z.din_ready, bus_z.busy, bus_z.done, bus_z.err} !== '0) begin
        errors++;
        $display("FAIL idle_outputs: cycle %0d a: bl=%h wl=%b busy=%b done=%b err=%b, required all 0",
                 c, bus_a.bl, bus_a.wl, bus_a.busy, bus_a.done, bus_a.err);
      end
    end
    bus_a.din_valid = 1'b0;
    $display("reset/idle done");
  endtask

  task automatic test_basic_load();
    int el, clr;
    bit st;
    frame_mem[0] = 8'hA5; frame_mem[1] = 8'h3C; frame_mem[2] = 8'hFF; frame_mem[3] = 8'h01;
    push_frames(WL);
    run_load(100, 1'b1, -1, -1, el, clr, st);
    $display("basic load: elapsed=%0d clear_cycles=%0d", el, clr);
    checks++;
    if (el !== FULL_A) begin
      errors++;
      $display("FAIL basic_done_time: got %0d, required %0d", el, FULL_A);
    end
    checks++;
    if (clr !== CLR) begin
      errors++;
      $display("FAIL basic_clear_len: got %0d, required %0d", clr, CLR);
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL basic_missing_writes: got %0d pending, required 0", sb_q.size());
    end
    checks++;
    if ({bus_a.done, bus_a.busy, bus_a.err, bus_a.bl} !== {1'b1, 1'b0, 1'b0, 8'h01}) begin
      errors++;
      $display("FAIL basic_done_state: got done=%b busy=%b err=%b bl=%h, required 1 0 0 01",
               bus_a.done, bus_a.busy, bus_a.err, bus_a.bl);
    end
  endtask

  task automatic test_overrun();
    int el, clr;
    bit st;
    bus_a.din_valid = 1'b1;
    @(posedge clk); #1;
    bus_a.din_valid = 1'b0;
    checks++;
    if (bus_a.err !== 1'b1) begin
      errors++;
      $display("FAIL overrun_err_set: got %b, required 1", bus_a.err);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus_a.err, bus_a.done} !== 2'b11) begin
      errors++;
      $display("FAIL overrun_err_sticky: got err=%b done=%b, required 1 1", bus_a.err, bus_a.done);
    end
    random_frames();
    push_frames(WL);
    bus_a.start = 1'b1;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    checks++;
    if ({bus_a.err, bus_a.done, bus_a.cfg_reset} !== 3'b001) begin
      errors++;
      $display("FAIL overrun_restart: got err=%b done=%b cfg=%b, required 0 0 1",
               bus_a.err, bus_a.done, bus_a.cfg_reset);
    end
    run_load(100, 1'b0, -1, -1, el, clr, st);
    $display("overrun reload: elapsed=%0d", el);
    checks++;
    if (el < 0 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL overrun_reload: got elapsed=%0d pending=%0d, required done and 0", el, sb_q.size());
    end
  endtask

  task automatic test_backpressure();
    int el, clr;
    bit st;
    random_frames();
    push_frames(WL);
    run_load(50, 1'b1, -1, -1, el, clr, st);
    $display("backpressure load: elapsed=%0d clear_cycles=%0d", el, clr);
    checks++;
    if (el < FULL_A || clr != CLR) begin
      errors++;
      $display("FAIL stall_timing: got elapsed=%0d clear=%0d, required >=%0d and %0d", el, clr, FULL_A, CLR);
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL stall_missing_writes: got %0d pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_ignored_start();
    int el, clr;
    bit st;
    random_frames();
    push_frames(WL);
    run_load(100, 1'b1, -1, 15, el, clr, st);
    $display("ignored start load: elapsed=%0d clear_cycles=%0d", el, clr);
    checks++;
    if (el !== FULL_A || clr !== CLR) begin
      errors++;
      $display("FAIL ignored_start: got elapsed=%0d clear=%0d, required %0d %0d", el, clr, FULL_A, CLR);
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL ignored_start_writes: got %0d pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_reset_mid_write();
    int el, clr;
    bit st;
    random_frames();
    push_frames(1);
    run_load(100, 1'b1, 1, -1, el, clr, st);
    checks++;
    if (st !== 1'b1) begin
      errors++;
      $display("FAIL midreset_reach_write: got %b, required 1", st);
    end
    reset_a = 1'b0;
    #1;
    checks++;
    if (bus_a.wl !== '0) begin
      errors++;
      $display("FAIL midreset_wl_async: got %b, required 0", bus_a.wl);
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_frame0: got %0d pending, required 0", sb_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
    reset_a = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus_a.wl, bus_a.busy, bus_a.done, bus_a.din_ready, bus_a.cfg_reset, bus_a.err} !== '0) begin
      errors++;
      $display("FAIL midreset_idle: got wl=%b busy=%b done=%b rdy=%b, required all 0",
               bus_a.wl, bus_a.busy, bus_a.done, bus_a.din_ready);
    end
    push_frames(WL);
    run_load(100, 1'b1, -1, -1, el, clr, st);
    $display("post-reset load: elapsed=%0d", el);
    checks++;
    if (el !== FULL_A || sb_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_reload: got elapsed=%0d pending=%0d, required %0d 0", el, sb_q.size(), FULL_A);
    end
  endtask

  task automatic test_zero_clear();
    sb_item_t zq[$];
    sb_item_t it;
    sb_item_t want;
    int   idx = 0;
    int   cyc = 0;
    int   el  = -1;
    int   clr = 0;
    logic rdy;
    random_frames();
    for (int i = 0; i < WL; i++) begin
      it.wl = '0; it.wl[i] = 1'b1; it.bl = frame_mem[i];
      zq.push_back(it);
    end
    bus_z.start = 1'b1;
    while (cyc < LOAD_BUDGET) begin
      bus_z.din_valid = (idx < WL * BL);
      bus_z.din       = (idx < WL * BL) ? frame_mem[idx / BL][BL - 1 - (idx % BL)] : 1'b0;
      rdy = bus_z.din_ready;
      @(posedge clk); #1;
      cyc++;
      bus_z.start = 1'b0;
      if (bus_z.din_valid && rdy) idx++;
      if (cyc == 1) begin
        checks++;
        if ({bus_z.din_ready, bus_z.cfg_reset} !== 2'b10) begin
          errors++;
          $display("FAIL zero_clear_first_ready: got rdy=%b cfg=%b, required 1 0",
                   bus_z.din_ready, bus_z.cfg_reset);
        end
      end
      if (bus_z.cfg_reset) clr++;
      if (bus_z.wl !== '0) begin
        $display("write z wl=%b bl=%h", bus_z.wl, bus_z.bl);
        checks++;
        if (zq.size() == 0) begin
          errors++;
          $display("FAIL zero_clear_unexpected: got wl=%b bl=%h, required no write", bus_z.wl, bus_z.bl);
        end else begin
          want = zq.pop_front();
          if (bus_z.wl !== want.wl || bus_z.bl !== want.bl) begin
            errors++;
            $display("FAIL zero_clear_frame: got wl=%b bl=%h, required wl=%b bl=%h",
                     bus_z.wl, bus_z.bl, want.wl, want.bl);
          end
        end
      end
      if (bus_z.done) begin
        el = cyc - 1;
        break;
      end
    end
    bus_z.din_valid = 1'b0;
    $display("zero clear load: elapsed=%0d", el);
    checks++;
    if (el !== FULL_Z || clr !== 0) begin
      errors++;
      $display("FAIL zero_clear_timing: got elapsed=%0d cfg_cycles=%0d, required %0d 0", el, clr, FULL_Z);
    end
    checks++;
    if (zq.size() != 0) begin
      errors++;
      $display("FAIL zero_clear_missing: got %0d pending, required 0", zq.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_overrun();
    test_backpressure();
    test_ignored_start();
    test_reset_mid_write();
    test_zero_clear();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
